// File: rtl/mux_lut_gate_array.sv
// mux_lut_gate_array: CH independent K-input programmable gates. Each channel
// holds a 2**K-bit truth table that drives a K-level tree of 2:1 mux cells.
// Tables are loaded serially, MSB first, through a valid/ready config port.
// After reset every table holds the K-input OR function.
// The evaluation path has one registered stage and never stalls.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   cfg_valid/ready    config bit handshake (ready is registered, state-only)
//   cfg_ch             target channel, latched on the first bit of a load
//   cfg_bit            truth-table bit, entry TT-1 first
//   busy               load in progress (SHIFT or COMMIT)
//   in_valid, in_data  operands; channel c uses in_data[c*K +: K]
//   out_valid,out_data registered results, one bit per channel

// 2:1 mux cell used as the leaf primitive of every lane's tree.
module mux2_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);
  assign y_o = s_i ? b_i : a_i;
endmodule

// One gate channel: truth-table register, mux tree and result register.
//   wr_en_i/wr_tt_i  replace the table (taken on the COMMIT edge)
//   in_valid_i/sel_i operand select; sel_i[0] drives tree level 0
//   out_o            registered tree output, held while in_valid_i is low
module mux_lut_lane #(
  parameter  int K  = 2,
  localparam int TT = 2**K
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [TT-1:0] wr_tt_i,
  input  logic          in_valid_i,
  input  logic [K-1:0]  sel_i,
  output logic          out_o
);
  localparam logic [TT-1:0] TT_OR = {{(TT-1){1'b1}}, 1'b0};

  logic [TT-1:0]   tbl_q;
  logic            out_q;
  // All tree levels packed into one vector: level l starts at
  // 2*TT - 2*(TT>>l), so level 0 is the table and bit 2*TT-2 is the root.
  logic [2*TT-2:0] node;

  assign node[TT-1:0] = tbl_q;

  for (genvar l = 0; l < K; l++) begin : g_lvl
    localparam int OI = 2*TT - 2*(TT >> l);
    localparam int OO = 2*TT - 2*(TT >> (l+1));
    for (genvar j = 0; j < (TT >> (l+1)); j++) begin : g_m
      mux2_cell u_mux (
        .a_i (node[OI+2*j]),
        .b_i (node[OI+2*j+1]),
        .s_i (sel_i[l]),
        .y_o (node[OO+j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= TT_OR;
      out_q <= 1'b0;
    end else begin
      if (wr_en_i)    tbl_q <= wr_tt_i;
      // Reads the pre-commit table on the COMMIT edge itself.
      if (in_valid_i) out_q <= node[2*TT-2];
    end
  end

  assign out_o = out_q;
endmodule

module mux_lut_gate_array #(
  parameter  int K  = 2,
  parameter  int CH = 4,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic          cfg_bit,
  output logic          busy,
  input  logic          in_valid,
  input  logic [CH*K-1:0] in_data,
  output logic          out_valid,
  output logic [CH-1:0] out_data
);
  localparam int TT     = 2**K;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} st_e;

  st_e           st_q;
  logic [TT-1:0] sh_q;
  logic [K:0]    cnt_q;
  logic [CW-1:0] ch_q;
  logic          cfg_ready_q;
  logic          busy_q;
  logic          hs;
  logic [TT-1:0] sh_d;
  logic [STAGES:0] vld_pipe;

  assign hs   = cfg_valid & cfg_ready_q;
  assign sh_d = {sh_q[TT-2:0], cfg_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      ch_q        <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (hs) begin
          ch_q   <= cfg_ch;
          sh_q   <= sh_d;
          cnt_q  <= (K+1)'(1);
          busy_q <= 1'b1;
          st_q   <= SHIFT;
        end
        SHIFT: if (hs) begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q + (K+1)'(1);
          if (cnt_q == (K+1)'(TT-1)) begin
            st_q        <= COMMIT;
            cfg_ready_q <= 1'b0;
          end
        end
        COMMIT: begin
          cnt_q       <= '0;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          st_q        <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;

  assign vld_pipe[0] = in_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end
  assign out_valid = vld_pipe[STAGES];

  // A latched channel index >= CH matches no lane, so that commit is dropped.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    mux_lut_lane #(.K(K)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    ((st_q == COMMIT) && (ch_q == CW'(c))),
      .wr_tt_i    (sh_q),
      .in_valid_i (in_valid),
      .sel_i      (in_data[c*K +: K]),
      .out_o      (out_data[c])
    );
  end
endmodule
